// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: opcodes, sequencer states and IR field positions.
package cpu_pkg;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam int unsigned OP_MSB = 15;
    localparam int unsigned OP_LSB = 13;
    localparam int unsigned RX_MSB = 12;
    localparam int unsigned RX_LSB = 10;
    localparam int unsigned RY_MSB = 9;
    localparam int unsigned RY_LSB = 7;

endpackage

// File: rtl/dec3to8.sv
// 3-bit to 8-bit one-hot decoder; all outputs low when en is low.
module dec3to8 (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: fetches into IR, then walks T0..T3 driving register enables,
// bus-source selects and ALU controls.
module control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned NREG = 8,
    parameter int unsigned DW   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic [DW-1:0]   din,
    output logic            ir_load,
    output logic [NREG-1:0] reg_in,
    output logic [NREG-1:0] reg_sel,
    output logic            din_out,
    output logic            g_out,
    output logic            a_in,
    output logic            g_in,
    output logic            addsub,
    output logic            done
);

    state_t        state_q, state_d;
    logic [DW-1:0] ir_q;

    logic [2:0] opcode;
    logic [2:0] rx;
    logic [2:0] ry;
    logic       is_alu;

    assign opcode = ir_q[OP_MSB:OP_LSB];
    assign rx     = ir_q[RX_MSB:RX_LSB];
    assign ry     = ir_q[RY_MSB:RY_LSB];
    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);

    // Internal strobes before reset gating
    logic       ir_load_c;
    logic       in_en_c;
    logic       sel_en_c;
    logic       sel_rx_c;
    logic       din_out_c;
    logic       g_out_c;
    logic       a_in_c;
    logic       g_in_c;
    logic       addsub_c;
    logic       done_c;
    logic [2:0] sel_idx;
    logic [7:0] reg_in_dec;
    logic [7:0] reg_sel_dec;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ir_load_c) begin
                ir_q <= din;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_load_c = 1'b0;
        in_en_c   = 1'b0;
        sel_en_c  = 1'b0;
        sel_rx_c  = 1'b0;
        din_out_c = 1'b0;
        g_out_c   = 1'b0;
        a_in_c    = 1'b0;
        g_in_c    = 1'b0;
        addsub_c  = 1'b0;
        done_c    = 1'b0;

        unique case (state_q)
            T0: begin
                if (run) begin
                    ir_load_c = 1'b1;
                    state_d   = T1;
                end
            end
            T1: begin
                if (opcode == OP_MV) begin
                    sel_en_c = 1'b1;
                    in_en_c  = 1'b1;
                    done_c   = 1'b1;
                    state_d  = T0;
                end else if (opcode == OP_MVI) begin
                    din_out_c = 1'b1;
                    in_en_c   = 1'b1;
                    done_c    = 1'b1;
                    state_d   = T0;
                end else if (is_alu) begin
                    // First operand comes from rX into A
                    sel_en_c = 1'b1;
                    sel_rx_c = 1'b1;
                    a_in_c   = 1'b1;
                    state_d  = T2;
                end else begin
                    done_c  = 1'b1;
                    state_d = T0;
                end
            end
            T2: begin
                sel_en_c = 1'b1;
                g_in_c   = 1'b1;
                addsub_c = opcode[0];
                state_d  = T3;
            end
            T3: begin
                g_out_c = 1'b1;
                in_en_c = 1'b1;
                done_c  = 1'b1;
                state_d = T0;
            end
            default: state_d = T0;
        endcase
    end

    assign sel_idx = sel_rx_c ? rx : ry;

    dec3to8 u_dec_in (
        .sel (rx),
        .en  (in_en_c && !reset),
        .y   (reg_in_dec)
    );

    dec3to8 u_dec_sel (
        .sel (sel_idx),
        .en  (sel_en_c && !reset),
        .y   (reg_sel_dec)
    );

    assign reg_in  = reg_in_dec[NREG-1:0];
    assign reg_sel = reg_sel_dec[NREG-1:0];

    // Reset aborts mid-instruction, so every enable is squashed while it is high
    assign ir_load = ir_load_c && !reset;
    assign din_out = din_out_c && !reset;
    assign g_out   = g_out_c   && !reset;
    assign a_in    = a_in_c    && !reset;
    assign g_in    = g_in_c    && !reset;
    assign addsub  = addsub_c  && !reset;
    assign done    = done_c    && !reset;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-cycle expected output vectors go through a
// scoreboard queue and are compared mid-cycle.
module tb_control_unit;

    logic        clk;
    logic        reset;
    logic        run;
    logic [15:0] din;
    logic        ir_load;
    logic [7:0]  reg_in;
    logic [7:0]  reg_sel;
    logic        din_out;
    logic        g_out;
    logic        a_in;
    logic        g_in;
    logic        addsub;
    logic        done;

    int n_cmp;
    int n_bad;

    logic [22:0] exp_q[$];
    string       name_q[$];

    control_unit #(
        .NREG (8),
        .DW   (16)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .din     (din),
        .ir_load (ir_load),
        .reg_in  (reg_in),
        .reg_sel (reg_sel),
        .din_out (din_out),
        .g_out   (g_out),
        .a_in    (a_in),
        .g_in    (g_in),
        .addsub  (addsub),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ir_load, reg_in, reg_sel, din_out, g_out, a_in, g_in, addsub, done}
    function automatic logic [22:0] ev(input logic irl, input logic [7:0] rin,
                                       input logic [7:0] rsel, input logic dout,
                                       input logic gout, input logic ain, input logic gin,
                                       input logic as, input logic dn);
        return {irl, rin, rsel, dout, gout, ain, gin, as, dn};
    endfunction

    localparam logic [22:0] IDLE = 23'h0;

    // One clock cycle: drive inputs after the edge, expect vector, compare at negedge
    task automatic step(input logic rst, input logic r, input logic [15:0] d,
                        input logic [22:0] exp, input string nm);
        logic [22:0] got;
        logic [22:0] want;
        string       wn;
        int          srcs;
        @(posedge clk);
        #1;
        reset = rst;
        run   = r;
        din   = d;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(negedge clk);
        got  = {ir_load, reg_in, reg_sel, din_out, g_out, a_in, g_in, addsub, done};
        want = exp_q.pop_front();
        wn   = name_q.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %06h required %06h", wn, got, want);
        end
        srcs = $countones({reg_sel, din_out, g_out});
        n_cmp++;
        if (srcs > 1 || $countones(reg_in) > 1) begin
            n_bad++;
            $display("FAIL %s onehot: bus sources %0d reg_in %02h required <=1 each",
                     wn, srcs, reg_in);
        end
    endtask

    task automatic test_reset_mvi();
        step(1'b1, 1'b1, 16'h2000, IDLE, "reset cycle 1");
        step(1'b1, 1'b1, 16'h2000, IDLE, "reset cycle 2");
        step(1'b0, 1'b0, 16'h2000, IDLE, "post-reset idle");
        step(1'b0, 1'b1, 16'h2000, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "mvi T0");
        step(1'b0, 1'b0, 16'hABCD, ev(0, 8'h01, 8'h00, 1, 0, 0, 0, 0, 1), "mvi T1");
    endtask

    task automatic test_mv();
        step(1'b0, 1'b1, 16'h0A80, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "mv T0");
        step(1'b0, 1'b0, 16'h0000, ev(0, 8'h04, 8'h20, 0, 0, 0, 0, 0, 1), "mv T1");
        step(1'b0, 1'b0, 16'h0000, IDLE, "mv back in T0");
    endtask

    task automatic test_add();
        step(1'b0, 1'b1, 16'h4580, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "add T0");
        step(1'b0, 1'b0, 16'h0000, ev(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0), "add T1");
        step(1'b0, 1'b0, 16'h0000, ev(0, 8'h00, 8'h08, 0, 0, 0, 1, 0, 0), "add T2");
        step(1'b0, 1'b0, 16'h0000, ev(0, 8'h02, 8'h00, 0, 1, 0, 0, 0, 1), "add T3");
        step(1'b0, 1'b0, 16'h0000, IDLE, "add back in T0");
    endtask

    // run held high across sub then a reserved opcode; run dropped during T2
    task automatic test_back_to_back();
        step(1'b0, 1'b1, 16'h7F80, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "sub T0");
        step(1'b0, 1'b1, 16'h7F80, ev(0, 8'h00, 8'h80, 0, 0, 1, 0, 0, 0), "sub T1");
        step(1'b0, 1'b0, 16'h7F80, ev(0, 8'h00, 8'h80, 0, 0, 0, 1, 1, 0), "sub T2 run low");
        step(1'b0, 1'b1, 16'h7F80, ev(0, 8'h80, 8'h00, 0, 1, 0, 0, 0, 1), "sub T3");
        step(1'b0, 1'b1, 16'h8000, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "rsvd T0");
        step(1'b0, 1'b1, 16'h0A80, ev(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1), "rsvd T1");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 16'h2000, IDLE, "run low holds T0");
        end
    endtask

    task automatic test_run_toggle_t2();
        step(1'b0, 1'b1, 16'h4580, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "tog T0");
        step(1'b0, 1'b0, 16'h0000, ev(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0), "tog T1");
        step(1'b0, 1'b1, 16'h7F80, ev(0, 8'h00, 8'h08, 0, 0, 0, 1, 0, 0), "tog T2 run high");
        step(1'b0, 1'b0, 16'h0000, ev(0, 8'h02, 8'h00, 0, 1, 0, 0, 0, 1), "tog T3");
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, 16'h4580, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "abort T0");
        step(1'b0, 1'b0, 16'h0000, ev(0, 8'h00, 8'h02, 0, 0, 1, 0, 0, 0), "abort T1");
        step(1'b1, 1'b0, 16'h0000, IDLE, "abort T2 under reset");
        step(1'b0, 1'b0, 16'h0000, IDLE, "abort after reset");
        n_cmp++;
        if (dut.ir_q !== 16'h0000) begin
            n_bad++;
            $display("FAIL abort ir cleared: got %04h required 0000", dut.ir_q);
        end
        step(1'b0, 1'b0, 16'h0000, IDLE, "abort no writeback 1");
        step(1'b0, 1'b0, 16'h0000, IDLE, "abort no writeback 2");
        // Controller must still accept a fresh instruction from T0
        step(1'b0, 1'b1, 16'h0A80, ev(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "restart T0");
        step(1'b0, 1'b0, 16'h0000, ev(0, 8'h04, 8'h20, 0, 0, 0, 0, 0, 1), "restart T1");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        run   = 1'b0;
        din   = 16'h0000;
        test_reset_mvi();
        test_mv();
        test_add();
        test_back_to_back();
        test_run_toggle_t2();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: got %0d entries required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction sequencer for the 16-bit CPU that sits directly upstream of the register file. It fetches a 16-bit instruction word from `din` into an internal instruction register (IR). It then steps through a fixed T0–T3 state sequence. In each state it drives the one-hot register load enables, the bus-source selects for the bus multiplexer that produces `buswires`, and the ALU controls. Each general register captures `buswires` on the clock edge at which its load enable is high.

## Interface

Parameters:
- `NREG`, default 8: number of general registers R0..R7; fixes the 3-bit register fields.
- `DW`, default 16: instruction/data word width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  reset; synchronous, active-high. This is already decided.
- `run`  in  1  start request; sampled only in T0.
- `din`  in  DW  instruction word in T0; immediate data word in T1 of `mvi`.
- `ir_load`  out  1  IR captures `din` this edge.
- `reg_in`  out  NREG  one-hot load enable per general register (R0 = bit 0).
- `reg_sel`  out  NREG  one-hot bus-source select for R0..R7.
- `din_out`  out  1  bus source = `din`.
- `g_out`  out  1  bus source = ALU result register G.
- `a_in`  out  1  ALU operand register A loads the bus.
- `g_in`  out  1  G loads the ALU result.
- `addsub`  out  1  ALU operation: 0 = add, 1 = subtract. Meaningful only when `g_in` = 1.
- `done`  out  1  last cycle of the current instruction.

## Operation

Instruction fields in IR:
- `[15:13]` opcode.
- `[12:10]` rX, the destination register.
- `[9:7]` rY, the source register.
- `[6:0]` ignored.

Opcodes:
- 000 `mv rX,rY`
- 001 `mvi rX,#D`
- 010 `add rX,rY`
- 011 `sub rX,rY`
- 100–111 reserved; executed as a no-op.

States are T0, T1, T2, T3. All outputs are combinationally decoded from the current state and IR (plus `run` in T0).

- **T0:**
  - `ir_load` = `run`.
  - If `run` = 1: next state T1, and IR <= `din`.
  - Otherwise: stay in T0.
- **T1:**
  - `mv`: `reg_sel[rY]`, `reg_in[rX]`, `done` → T0.
  - `mvi`: `din_out`, `reg_in[rX]`, `done` → T0.
  - `add`/`sub`: `reg_sel[rX]`, `a_in` → T2.
  - Reserved opcode: `done` only → T0.
- **T2** (`add`/`sub` only): `reg_sel[rY]`, `g_in`, `addsub` = opcode[0] → T3.
- **T3:** `g_out`, `reg_in[rX]`, `done` → T0.

Invariants:
- At most one of `reg_sel[*]`, `din_out`, `g_out` is high in any cycle.
- At most one bit of `reg_in` is high in any cycle.
- `run` is ignored in T1–T3.
- `run` held high gives back-to-back instructions: T0 follows every `done`, and there is no bubble beyond T0.
- When `rX` = `rY`, behaviour is unchanged; for example, `sub R7,R7` yields 0 in R7.

## Timing

- **Reset:** while `reset` = 1 at a rising edge, state <= T0 and IR <= 0.
- **Outputs during and after reset:** `reg_in`, `reg_sel`, `din_out`, `g_out`, `a_in`, `g_in`, `addsub`, `done` and `ir_load` are 0 while `reset` is high. After reset releases, outputs are 0 until `run` is asserted.
- **Reset mid-instruction:** aborts the instruction at that edge. No partial writeback occurs afterwards; any enable already high in that cycle is gated to 0.
- **Latency:**
  - `mv`, `mvi` and reserved opcodes: 2 cycles (T0, T1).
  - `add`, `sub`: 4 cycles (T0–T3).
- **`done`:** high for exactly one cycle per instruction.
- **Destination write:** the destination register is written at the edge that ends the `done` cycle.
- **`din` requirements:**
  - Must be stable with the instruction word during the T0 cycle in which `run` = 1.
  - For `mvi`, must be stable with the immediate data during T1.

## Structure

- Shared package `cpu_pkg`:
  - opcode constants `OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`;
  - state enum `T0..T3` (2-bit);
  - IR field bit positions.
- Sub-module `dec3to8`: 3-bit to 8-bit one-hot decoder with an enable input. It is instantiated twice, once for `reg_in` from rX and once for `reg_sel`.
- The IR is a 16-bit register inside `control_unit`.

## Test plan

- **Reset, then `mvi R0`:** assert `reset` for 2 cycles, then `run` = 1 with `din` = 16'h2000, then `din` = 16'hABCD. Required:
  - all outputs 0 during reset;
  - T0: `ir_load` = 1;
  - T1: `din_out` = 1, `reg_in` = 8'h01, `done` = 1.
- **`mv R2,R5`** (`din` = 16'h0A80): T1 shows `reg_sel` = 8'h20, `reg_in` = 8'h04, `done` = 1; the controller is back in T0 the next cycle.
- **`add R1,R3`** (16'h4580):
  - T1: `reg_sel` = 8'h02, `a_in` = 1;
  - T2: `reg_sel` = 8'h08, `g_in` = 1, `addsub` = 0;
  - T3: `g_out` = 1, `reg_in` = 8'h02, `done` = 1.
- **`sub R7,R7`** (16'h7F80): T2 shows `addsub` = 1 and `reg_sel` = 8'h80; T3 shows `reg_in` = 8'h80. Across the whole run, no cycle has more than one bus source active.
- **Reserved opcode and `run` handling:**
  - 16'h8000 gives `done` = 1 in T1 with all enables 0.
  - `run` = 0 holds T0 indefinitely with `ir_load` = 0.
  - Toggling `run` during T2 has no effect.
- **Reset mid-instruction:** assert `reset` during T2 of `add`. Required: T0 on the next cycle, IR = 0, and no `reg_in` bit or `done` pulse follows.
